// File: rtl/move_display_sequencer.sv
// Buffers one checkers move (list of squares) and cycles its hops as "from -> to" digit indices
// for four 7-seg encoders. Optional to-digit blink is built when BLINK_LEDS_EN is defined.
module move_display_sequencer #(
    parameter int MAX_SQUARES  = 8,
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLINK_HALF   = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       sq_valid,
    output logic       sq_ready,
    input  logic [2:0] sq_row,
    input  logic [2:0] sq_col,
    input  logic       sq_last,
    output logic [4:0] digit_idx3,
    output logic [4:0] digit_idx2,
    output logic [4:0] digit_idx1,
    output logic [4:0] digit_idx0,
    output logic [3:0] digit_blank,
    output logic [2:0] pair_idx,
    output logic       showing
);

    localparam int AW = (MAX_SQUARES > 1) ? $clog2(MAX_SQUARES) : 1;
    localparam int CW = $clog2(MAX_SQUARES) + 1;
    localparam int DW = $clog2(DWELL_CYCLES);

    if (MAX_SQUARES < 2 || DWELL_CYCLES < 2 || BLINK_HALF < 1) begin : g_bad_cfg
        $error("move_display_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_new;
    logic [AW-1:0]   pair_q, pair_to, slot;
    logic [DW-1:0]   dwell_q;
    logic [2:0]      row_mem [MAX_SQUARES];
    logic [2:0]      col_mem [MAX_SQUARES];
    logic            accept, dwell_done, last_pair, to_blank;

    assign sq_ready   = (state_q == SHOW) || (count_q < CW'(MAX_SQUARES));
    assign accept     = sq_valid && sq_ready && !clear;
    assign dwell_done = (state_q == SHOW) && (dwell_q == DW'(DWELL_CYCLES - 1));
    assign last_pair  = (count_q < CW'(2)) || (CW'(pair_q) == count_q - CW'(2));
    assign slot       = (state_q == LOAD) ? count_q[AW-1:0] : '0;
    assign count_new  = (state_q == LOAD) ? count_q + CW'(1) : CW'(1);
    assign pair_to    = pair_q + AW'(1);
    assign showing    = (state_q == SHOW);
    assign pair_idx   = 3'(pair_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A square accepted in SHOW restarts the move with it as the new start square.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (accept) begin
            if (sq_last || count_new == CW'(MAX_SQUARES)) state_d = SHOW;
            else                                          state_d = LOAD;
        end
    end

    // Stage p0: move buffer, pair pointer and dwell timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            pair_q  <= '0;
            dwell_q <= '0;
            for (int i = 0; i < MAX_SQUARES; i++) begin
                row_mem[i] <= '0;
                col_mem[i] <= '0;
            end
        end else if (clear) begin
            count_q <= '0;
            pair_q  <= '0;
            dwell_q <= '0;
        end else if (accept) begin
            row_mem[slot] <= sq_row;
            col_mem[slot] <= sq_col;
            count_q       <= count_new;
            pair_q        <= '0;
            dwell_q       <= '0;
        end else if (state_q == SHOW) begin
            if (dwell_done) begin
                dwell_q <= '0;
                pair_q  <= last_pair ? '0 : pair_to;
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

`ifdef BLINK_LEDS_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [BW-1:0] blink_q;
    logic          blink_on_q;

    // Blink phase restarts unblanked on SHOW entry and on every pair advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_q    <= '0;
            blink_on_q <= 1'b0;
        end else if (clear || accept || dwell_done || state_q != SHOW) begin
            blink_q    <= '0;
            blink_on_q <= 1'b0;
        end else if (blink_q == BW'(BLINK_HALF - 1)) begin
            blink_q    <= '0;
            blink_on_q <= !blink_on_q;
        end else begin
            blink_q <= blink_q + BW'(1);
        end
    end

    assign to_blank = blink_on_q;
`else
    assign to_blank = 1'b0;
`endif

    // Stage p1: registered digit indices and blanking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit_idx3  <= '0;
            digit_idx2  <= '0;
            digit_idx1  <= '0;
            digit_idx0  <= '0;
            digit_blank <= 4'hF;
        end else if (clear || state_q != SHOW) begin
            digit_idx3  <= '0;
            digit_idx2  <= '0;
            digit_idx1  <= '0;
            digit_idx0  <= '0;
            digit_blank <= 4'hF;
        end else if (count_q >= CW'(2)) begin
            digit_idx3  <= 5'd9 + {2'b00, col_mem[pair_q]};
            digit_idx2  <= 5'd1 + {2'b00, row_mem[pair_q]};
            digit_idx1  <= 5'd9 + {2'b00, col_mem[pair_to]};
            digit_idx0  <= 5'd1 + {2'b00, row_mem[pair_to]};
            digit_blank <= {2'b00, {2{to_blank}}};
        end else begin
            digit_idx3  <= 5'd9 + {2'b00, col_mem[pair_q]};
            digit_idx2  <= 5'd1 + {2'b00, row_mem[pair_q]};
            digit_idx1  <= '0;
            digit_idx0  <= '0;
            digit_blank <= 4'h3;
        end
    end

endmodule

// File: tb/tb_move_display_sequencer.sv
// Directed bench for move_display_sequencer: a square-list model predicts each displayed pair
// into a scoreboard queue that is drained as the DUT shows the move.
module tb_move_display_sequencer;

    localparam int DWELL = 4;
    localparam int BH    = 2;

    logic       clock, reset, clear, sq_valid, sq_ready, sq_last, showing;
    logic [2:0] sq_row, sq_col, pair_idx;
    logic [4:0] digit_idx3, digit_idx2, digit_idx1, digit_idx0;
    logic [3:0] digit_blank;

    move_display_sequencer #(
        .MAX_SQUARES (8),
        .DWELL_CYCLES(DWELL),
        .BLINK_HALF  (BH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .sq_valid   (sq_valid),
        .sq_ready   (sq_ready),
        .sq_row     (sq_row),
        .sq_col     (sq_col),
        .sq_last    (sq_last),
        .digit_idx3 (digit_idx3),
        .digit_idx2 (digit_idx2),
        .digit_idx1 (digit_idx1),
        .digit_idx0 (digit_idx0),
        .digit_blank(digit_blank),
        .pair_idx   (pair_idx),
        .showing    (showing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          mrow[8];
    int          mcol[8];
    int          mn;
    logic [23:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected {idx3,idx2,idx1,idx0,blank} for the c-th display cycle after SHOW entry.
    function automatic logic [23:0] exp_disp(input int c);
        int np;
        int p;
        logic [3:0] bl;
        np = (mn >= 2) ? mn - 1 : 1;
        p  = (c / DWELL) % np;
        bl = 4'h0;
        if (mn < 2) return {5'(9 + mcol[0]), 5'(1 + mrow[0]), 5'd0, 5'd0, 4'h3};
`ifdef BLINK_LEDS_EN
        if ((((c % DWELL) / BH) % 2) == 1) bl = 4'h3;
`endif
        return {5'(9 + mcol[p]), 5'(1 + mrow[p]), 5'(9 + mcol[p+1]), 5'(1 + mrow[p+1]), bl};
    endfunction

    task automatic send_move(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            sq_row   = 3'(mrow[i]);
            sq_col   = 3'(mcol[i]);
            sq_last  = with_last && (i == n - 1);
            sq_valid = 1'b1;
            check("sq_ready_offer", 32'(sq_ready), 32'd1);
            step();
            sq_valid = 1'b0;
            sq_last  = 1'b0;
        end
    endtask

    task automatic run_show(input int ncyc);
        int np;
        logic [23:0] exp;
        np = (mn >= 2) ? mn - 1 : 1;
        check("showing_entry", 32'(showing), 32'd1);
        check("pair_entry", 32'(pair_idx), 32'd0);
        for (int c = 0; c < ncyc; c++) sb_q.push_back(exp_disp(c));
        for (int k = 1; k <= ncyc; k++) begin
            step();
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check("digits", 32'({digit_idx3, digit_idx2, digit_idx1, digit_idx0, digit_blank}),
                      32'(exp));
            end
            check("pair_idx", 32'(pair_idx), 32'((k / DWELL) % np));
            check("showing", 32'(showing), 32'd1);
            check("sq_ready_show", 32'(sq_ready), 32'd1);
        end
    endtask

    task automatic check_blank_idle(input string tag);
        check(tag, 32'({digit_idx3, digit_idx2, digit_idx1, digit_idx0, digit_blank}), 32'h00000F);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; sq_valid = 1'b0; sq_last = 1'b0;
        sq_row = '0; sq_col = '0;
        step();
        step();
        check_blank_idle("reset_digits");
        check("reset_showing", 32'(showing), 32'd0);
        check("reset_ready", 32'(sq_ready), 32'd1);
        check("reset_pair", 32'(pair_idx), 32'd0);
        reset = 1'b0;
        step();
        check_blank_idle("idle_digits");

        // Two-square move: 10,3,11,4 held for the whole dwell.
        mn = 2; mrow[0] = 2; mcol[0] = 1; mrow[1] = 3; mcol[1] = 2;
        send_move(2, 1'b1);
        run_show(12);

        // Three squares, started while showing: two pairs that wrap.
        mn = 3; mrow[0] = 0; mcol[0] = 0; mrow[1] = 2; mcol[1] = 2; mrow[2] = 4; mcol[2] = 4;
        send_move(3, 1'b1);
        run_show(12);

        // Full buffer without sq_last: SHOW on the eighth square, pair 6 wraps to 0.
        mn = 8;
        for (int i = 0; i < 8; i++) begin
            mrow[i] = i;
            mcol[i] = 7 - i;
        end
        send_move(8, 1'b0);
        run_show(32);

        // Single square: to digits blank.
        mn = 1; mrow[0] = 7; mcol[0] = 7;
        send_move(1, 1'b1);
        run_show(6);

        // Abort while showing, then clear beats a same-cycle square.
        mn = 3; mrow[0] = 0; mcol[0] = 0; mrow[1] = 2; mcol[1] = 2; mrow[2] = 4; mcol[2] = 4;
        send_move(3, 1'b1);
        run_show(4);
        mn = 1; mrow[0] = 1; mcol[0] = 1;
        send_move(1, 1'b0);
        check("abort_showing", 32'(showing), 32'd0);
        check("abort_pair", 32'(pair_idx), 32'd0);
        step();
        check_blank_idle("abort_digits");
        clear = 1'b1; sq_valid = 1'b1; sq_row = 3'd5; sq_col = 3'd5; sq_last = 1'b1;
        step();
        clear = 1'b0; sq_valid = 1'b0; sq_last = 1'b0;
        check("clear_showing", 32'(showing), 32'd0);
        check("clear_ready", 32'(sq_ready), 32'd1);
        check_blank_idle("clear_digits");
        step();
        check("clear_stays_idle", 32'(showing), 32'd0);
        check_blank_idle("clear_idle_digits");
        mn = 2; mrow[0] = 6; mcol[0] = 0; mrow[1] = 1; mcol[1] = 3;
        send_move(2, 1'b1);
        run_show(8);

        // Asynchronous reset in the middle of SHOW.
        reset = 1'b1;
        #1;
        check("async_reset_showing", 32'(showing), 32'd0);
        check_blank_idle("async_reset_digits");
        check("async_reset_pair", 32'(pair_idx), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_reset_showing", 32'(showing), 32'd0);
        check_blank_idle("post_reset_digits");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
